// File: rtl/ctrl_seq_pkg.sv
// Shared types and default timing for the multi-channel measurement sequencer.
package ctrl_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_START,
    S_TX_WAIT,
    S_RE_START,
    S_RE_WAIT,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  localparam int unsigned DEF_N_CH         = 4;
  localparam int unsigned DEF_DEBOUNCE_CYC = 1000000;
  localparam int unsigned DEF_TIMEOUT_CYC  = 100000;
  localparam int unsigned DEF_GAP_CYC      = 16;

  function automatic int unsigned ch_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ctrl_seq_debounce.sv
// Key conditioner: 2-FF synchroniser, stability counter and registered rising-edge pulse.
module key_debounce
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      stable    <= 1'b0;
      stable_d  <= 1'b0;
      key_press <= 1'b0;
      cnt       <= '0;
    end else begin
      sync1     <= key_in;
      sync2     <= sync1;
      stable_d  <= stable;
      key_press <= stable & ~stable_d;
      // Any sample equal to the stable level restarts the count.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ctrl_seq.sv
// Burst sequencer: walks the latched channel mask issuing Tx/Re start pulses,
// with per-wait timeout, inter-channel gap, continuous mode and key abort.
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter  int unsigned N_CH         = DEF_N_CH,
  parameter  int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter  int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
  parameter  int unsigned GAP_CYC      = DEF_GAP_CYC,
  localparam int unsigned CH_W         = ch_w(N_CH)
) (
  input  logic            clk_100,
  input  logic            rst,
  input  logic            key_in,
  input  logic [N_CH-1:0] ch_mask,
  input  logic            mode_cont,
  input  logic            over_tx,
  input  logic            over_re,
  output logic            en_tx,
  output logic            en_re,
  output logic [CH_W-1:0] ch_sel,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [CH_W-1:0] err_ch,
  output logic            temp_led
);

  localparam int unsigned TMR_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  state_t            state, state_d;
  logic              key_press;
  logic [N_CH-1:0]   mask_q;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [TMR_W-1:0]  timer;
  logic              err_q, led_q;
  logic [CH_W-1:0]   err_ch_q;
  logic              tmr_clr, tmr_inc, start, empty, tout, ch_load;
  logic              found_in, found_mask, found_up;
  logic [CH_W-1:0]   first_in, first_mask, next_up;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
    .clk      (clk_100),
    .rst      (rst),
    .key_in   (key_in),
    .key_press(key_press)
  );

  always_comb begin
    found_in   = 1'b0;
    found_mask = 1'b0;
    found_up   = 1'b0;
    first_in   = '0;
    first_mask = '0;
    next_up    = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ch_mask[i] && !found_in) begin
        found_in = 1'b1;
        first_in = CH_W'(i);
      end
      if (mask_q[i] && !found_mask) begin
        found_mask = 1'b1;
        first_mask = CH_W'(i);
      end
      if (mask_q[i] && (i > 32'(ch_q)) && !found_up) begin
        found_up = 1'b1;
        next_up  = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    start   = 1'b0;
    empty   = 1'b0;
    tout    = 1'b0;
    ch_load = 1'b0;
    ch_d    = ch_q;
    case (state)
      S_IDLE: begin
        if (key_press) begin
          if (ch_mask == '0) begin
            empty = 1'b1;
          end else begin
            start   = 1'b1;
            ch_load = 1'b1;
            ch_d    = first_in;
            state_d = S_TX_START;
          end
        end
      end
      S_TX_START: begin
        tmr_clr = 1'b1;
        state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (over_tx) begin
          state_d = S_RE_START;
        end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
          tout    = 1'b1;
          state_d = S_ERR;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      S_RE_START: begin
        tmr_clr = 1'b1;
        state_d = S_RE_WAIT;
      end
      S_RE_WAIT: begin
        if (over_re) begin
          tmr_clr = 1'b1;
          state_d = S_GAP;
        end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
          tout    = 1'b1;
          state_d = S_ERR;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      S_GAP: begin
        if (timer == TMR_W'(GAP_CYC - 1)) begin
          tmr_clr = 1'b1;
          if (found_up) begin
            ch_load = 1'b1;
            ch_d    = next_up;
            state_d = S_TX_START;
          end else if (mode_cont) begin
            ch_load = 1'b1;
            ch_d    = first_mask;
            state_d = S_TX_START;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          tmr_inc = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides whatever the active state decided, including a same-cycle timeout.
    if (state != S_IDLE && key_press) begin
      state_d = S_IDLE;
      tout    = 1'b0;
      ch_load = 1'b0;
      tmr_clr = 1'b1;
      tmr_inc = 1'b0;
    end
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      state    <= S_IDLE;
      mask_q   <= '0;
      ch_q     <= '0;
      timer    <= '0;
      err_q    <= 1'b0;
      err_ch_q <= '0;
      led_q    <= 1'b0;
    end else begin
      state <= state_d;
      if (key_press) led_q <= ~led_q;
      if (start) begin
        mask_q <= ch_mask;
        err_q  <= 1'b0;
      end
      if (empty) begin
        mask_q   <= ch_mask;
        err_q    <= 1'b1;
        err_ch_q <= '1;
      end
      if (tout) begin
        err_q    <= 1'b1;
        err_ch_q <= ch_q;
      end
      if (ch_load) ch_q <= ch_d;
      if (tmr_clr)      timer <= '0;
      else if (tmr_inc) timer <= timer + 1'b1;
    end
  end

  assign en_tx    = (state == S_TX_START);
  assign en_re    = (state == S_RE_START);
  assign done     = (state == S_DONE);
  assign busy     = state inside {S_TX_START, S_TX_WAIT, S_RE_START, S_RE_WAIT, S_GAP};
  assign ch_sel   = ch_q;
  assign err      = err_q;
  assign err_ch   = err_ch_q;
  assign temp_led = led_q;

endmodule
